// File: rtl/rr_arbiter_16.sv
// rtl/rr_arbiter_16.sv - 16-requester round-robin arbiter with registered one-hot/encoded grant.
// Optional forced release after MAX_HOLD grant cycles when TIMEOUT_EN is defined.
module rr_arbiter_16 #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] gnt,
    output logic [3:0]  out,
    output logic        v,
    output logic        timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] gnt_q, gnt_d;
    logic [3:0]  out_q, out_d;
    logic        v_q, v_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        timeout_q, timeout_d;

    logic        found;
    logic [3:0]  win;
    logic [3:0]  idx;
    logic        release_n;

`ifdef TIMEOUT_EN
    logic [7:0]  hold_q, hold_d;
    logic        forced;
`endif

    // Search starts just after the last served index, so it ends up lowest priority.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int i = 1; i <= 16; i++) begin
            idx = ptr_q + 4'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        out_d     = out_q;
        v_d       = v_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        release_n = done | ~req[out_q];
`ifdef TIMEOUT_EN
        hold_d    = hold_q;
        forced    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = 16'h0000;
                v_d   = 1'b0;
                if (found) begin
                    gnt_d   = 16'h0001 << win;
                    out_d   = win;
                    v_d     = 1'b1;
                    state_d = GRANT;
`ifdef TIMEOUT_EN
                    hold_d  = 8'd1;
`endif
                end
            end
            GRANT: begin
`ifdef TIMEOUT_EN
                hold_d = hold_q + 8'd1;
                forced = (hold_q == 8'(MAX_HOLD)) && !release_n;
                if (release_n || forced) begin
                    gnt_d     = 16'h0000;
                    v_d       = 1'b0;
                    ptr_d     = out_q;
                    state_d   = IDLE;
                    timeout_d = forced;
                end
`else
                if (release_n) begin
                    gnt_d     = 16'h0000;
                    v_d       = 1'b0;
                    ptr_d     = out_q;
                    state_d   = IDLE;
                    // Zero for every legal MAX_HOLD; no forced release without the hold counter.
                    timeout_d = (MAX_HOLD < 1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 16'h0000;
            out_q     <= 4'd0;
            v_q       <= 1'b0;
            ptr_q     <= 4'd15;
            timeout_q <= 1'b0;
`ifdef TIMEOUT_EN
            hold_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            out_q     <= out_d;
            v_q       <= v_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
`ifdef TIMEOUT_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign out     = out_q;
    assign v       = v_q;
    assign timeout = timeout_q;

endmodule
